// File: rtl/ccip_if_pkg.sv
// Minimal subset of the CCI-P interface types used by the host-channel bridge.
// Field order and encodings follow the shell definitions; the address is widened to 64 bits.
package ccip_if_pkg;

   typedef logic [63:0]  t_ccip_clAddr;
   typedef logic [15:0]  t_ccip_mdata;
   typedef logic [511:0] t_ccip_clData;

   typedef enum logic [1:0] {eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3} t_ccip_vc;
   typedef enum logic [1:0] {eCL_LEN_1 = 2'h0, eCL_LEN_2 = 2'h1, eCL_LEN_4 = 2'h3} t_ccip_clLen;
   typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
   typedef enum logic [3:0] {eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRPUSH_I = 4'h2} t_ccip_c1_req;

   typedef struct packed {
      t_ccip_vc     vc_sel;
      logic [1:0]   rsvd1;
      t_ccip_clLen  cl_len;
      t_ccip_c0_req req_type;
      logic [5:0]   rsvd0;
      t_ccip_clAddr address;
      t_ccip_mdata  mdata;
   } t_ccip_c0_ReqMemHdr;

   typedef struct packed {
      logic [5:0]   rsvd2;
      t_ccip_vc     vc_sel;
      logic         sop;
      logic         rsvd1;
      t_ccip_clLen  cl_len;
      t_ccip_c1_req req_type;
      logic [5:0]   rsvd0;
      t_ccip_clAddr address;
      t_ccip_mdata  mdata;
   } t_ccip_c1_ReqMemHdr;

   typedef struct packed {
      t_ccip_vc    vc_used;
      logic        rsvd1;
      logic        hit_miss;
      logic [1:0]  rsvd0;
      logic [1:0]  cl_num;
      logic [3:0]  resp_type;
      t_ccip_mdata mdata;
   } t_ccip_c0_RspMemHdr;

   typedef struct packed {
      t_ccip_vc    vc_used;
      logic        rsvd1;
      logic        hit_miss;
      logic        format;
      logic        rsvd0;
      logic [1:0]  cl_num;
      logic [3:0]  resp_type;
      t_ccip_mdata mdata;
   } t_ccip_c1_RspMemHdr;

   typedef struct packed {
      t_ccip_c0_ReqMemHdr hdr;
      logic               valid;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      t_ccip_clData       data;
      logic               valid;
   } t_if_ccip_c1_Tx;

   typedef struct packed {
      logic [8:0]  tid;
      logic        mmioRdValid;
      logic [63:0] data;
   } t_if_ccip_c2_Tx;

   typedef struct packed {
      t_if_ccip_c0_Tx c0;
      t_if_ccip_c1_Tx c1;
      t_if_ccip_c2_Tx c2;
   } t_if_ccip_Tx;

   typedef struct packed {
      t_ccip_c0_RspMemHdr hdr;
      t_ccip_clData       data;
      logic               rspValid;
      logic               mmioRdValid;
      logic               mmioWrValid;
   } t_if_ccip_c0_Rx;

   typedef struct packed {
      t_ccip_c1_RspMemHdr hdr;
      logic               rspValid;
   } t_if_ccip_c1_Rx;

   typedef struct packed {
      logic           c0TxAlmFull;
      logic           c1TxAlmFull;
      t_if_ccip_c0_Rx c0;
      t_if_ccip_c1_Rx c1;
   } t_if_ccip_Rx;

endpackage

// File: rtl/ccip_mux_bridge_pkg.sv
// Shared definitions for the multi-client CCI-P bridge: mdata layout, counter type
// and request-header builders.
package ccip_mux_pkg;
   import ccip_if_pkg::*;

   localparam int MDATA_W      = 16;
   localparam int MDATA_ID_MSB = 15;

   typedef logic [7:0] t_cnt;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic t_ccip_c0_ReqMemHdr mk_rd_hdr(input t_ccip_clAddr addr, input t_ccip_mdata md);
      t_ccip_c0_ReqMemHdr h;
      h          = '0;
      h.vc_sel   = eVC_VA;
      h.cl_len   = eCL_LEN_1;
      h.req_type = eREQ_RDLINE_I;
      h.address  = addr;
      h.mdata    = md;
      return h;
   endfunction

   function automatic t_ccip_c1_ReqMemHdr mk_wr_hdr(input t_ccip_clAddr addr, input t_ccip_mdata md);
      t_ccip_c1_ReqMemHdr h;
      h          = '0;
      h.vc_sel   = eVC_VA;
      h.sop      = 1'b1;
      h.cl_len   = eCL_LEN_1;
      h.req_type = eREQ_WRLINE_I;
      h.address  = addr;
      h.mdata    = md;
      return h;
   endfunction

endpackage

// File: rtl/ccip_mux_bridge_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer; the pointer
// moves past the winner only when the grant is actually taken.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_i,
   input  logic         en_i,
   input  logic         adv_i,
   output logic [N-1:0] grant_o
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;

   always_comb begin
      int j;
      logic [PW-1:0] jj;
      j       = 0;
      jj      = '0;
      grant_o = '0;
      ptr_d   = ptr_q;
      // Walk offsets from far to near so the nearest requester overwrites the rest.
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(ptr_q) + k;
         if (j >= N) j = j - N;
         jj = PW'(j);
         if (en_i && req_i[jj]) begin
            grant_o     = '0;
            grant_o[jj] = 1'b1;
            ptr_d       = (j == N - 1) ? '0 : PW'(j + 1);
         end
      end
      if (!adv_i) ptr_d = ptr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/ccip_mux_bridge.sv
// Multiplexes per-client read/write request streams onto CCI-P c0/c1 TX and routes
// responses back by the client ID held in the top bits of mdata.
module ccip_mux_bridge
   import ccip_if_pkg::*, ccip_mux_pkg::*;
#(
   parameter int NUM_CLIENTS     = 4,
   parameter int MAX_OUTSTANDING = 64,
   parameter int ID_W            = id_width(NUM_CLIENTS),
   parameter int CTAG_W          = MDATA_W - ID_W
) (
   input  logic                               clk,
   input  logic                               SoftReset,
   input  t_if_ccip_Rx                        cp2af_sRx,
   output t_if_ccip_Tx                        af2cp_sTx,
   input  logic [NUM_CLIENTS-1:0]             rd_req_valid,
   output logic [NUM_CLIENTS-1:0]             rd_req_ready,
   input  logic [NUM_CLIENTS-1:0][63:0]       rd_req_addr,
   input  logic [NUM_CLIENTS-1:0][CTAG_W-1:0] rd_req_tag,
   output logic [NUM_CLIENTS-1:0]             rd_rsp_valid,
   output logic [CTAG_W-1:0]                  rd_rsp_tag,
   output logic [511:0]                       rd_rsp_data,
   input  logic [NUM_CLIENTS-1:0]             wr_req_valid,
   output logic [NUM_CLIENTS-1:0]             wr_req_ready,
   input  logic [NUM_CLIENTS-1:0][63:0]       wr_req_addr,
   input  logic [NUM_CLIENTS-1:0][CTAG_W-1:0] wr_req_tag,
   input  logic [NUM_CLIENTS-1:0][511:0]      wr_req_data,
   output logic [NUM_CLIENTS-1:0]             wr_rsp_valid,
   output logic [CTAG_W-1:0]                  wr_rsp_tag,
   output logic                               idle,
   output logic                               err_orphan
);
   t_cnt rd_cnt_q [NUM_CLIENTS];
   t_cnt rd_cnt_d [NUM_CLIENTS];
   t_cnt wr_cnt_q [NUM_CLIENTS];
   t_cnt wr_cnt_d [NUM_CLIENTS];

   logic [NUM_CLIENTS-1:0] rd_elig, wr_elig, rd_gnt, wr_gnt, rd_hit, wr_hit;
   logic [NUM_CLIENTS-1:0] rd_rsp_valid_q, wr_rsp_valid_q;
   logic                   rd_en, wr_en, rd_acc, wr_acc, rd_rsp_in, wr_rsp_in, orphan;
   logic [ID_W-1:0]        rd_gid, wr_gid, rd_rsp_id, wr_rsp_id;
   logic [63:0]            rd_addr_sel, wr_addr_sel;
   logic [CTAG_W-1:0]      rd_tag_sel, wr_tag_sel, rd_rsp_tag_q, wr_rsp_tag_q;
   logic [511:0]           wr_data_sel, c1_data_q, rd_rsp_data_q;
   logic                   c0_valid_q, c1_valid_q, err_q;
   t_ccip_c0_ReqMemHdr     c0_hdr_q;
   t_ccip_c1_ReqMemHdr     c1_hdr_q;
   logic                   unused_rx;

   // Counter update; a response against an empty counter holds it at zero.
   function automatic t_cnt cnt_next(input t_cnt c, input logic inc, input logic dec);
      if (inc && !dec) return c + 8'd1;
      if (dec && !inc && c != '0) return c - 8'd1;
      return c;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         rd_elig[i] = rd_req_valid[i] && (rd_cnt_q[i] < t_cnt'(MAX_OUTSTANDING));
         wr_elig[i] = wr_req_valid[i] && (wr_cnt_q[i] < t_cnt'(MAX_OUTSTANDING));
      end
   end

   assign rd_en = !cp2af_sRx.c0TxAlmFull && !SoftReset;
   assign wr_en = !cp2af_sRx.c1TxAlmFull && !SoftReset;

   rr_arbiter #(.N(NUM_CLIENTS)) u_rd_arb (
      .clk(clk), .rst(SoftReset), .req_i(rd_elig), .en_i(rd_en), .adv_i(rd_acc), .grant_o(rd_gnt)
   );
   rr_arbiter #(.N(NUM_CLIENTS)) u_wr_arb (
      .clk(clk), .rst(SoftReset), .req_i(wr_elig), .en_i(wr_en), .adv_i(wr_acc), .grant_o(wr_gnt)
   );

   assign rd_req_ready = rd_gnt;
   assign wr_req_ready = wr_gnt;
   assign rd_acc       = |rd_gnt;
   assign wr_acc       = |wr_gnt;

   always_comb begin
      rd_gid = '0; rd_addr_sel = '0; rd_tag_sel = '0;
      wr_gid = '0; wr_addr_sel = '0; wr_tag_sel = '0; wr_data_sel = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (rd_gnt[i]) begin
            rd_gid      = ID_W'(i);
            rd_addr_sel = rd_req_addr[i];
            rd_tag_sel  = rd_req_tag[i];
         end
         if (wr_gnt[i]) begin
            wr_gid      = ID_W'(i);
            wr_addr_sel = wr_req_addr[i];
            wr_tag_sel  = wr_req_tag[i];
            wr_data_sel = wr_req_data[i];
         end
      end
   end

   // Response decode: one-hot hit per client, orphan on unknown ID or empty counter.
   always_comb begin
      rd_rsp_in = cp2af_sRx.c0.rspValid && !cp2af_sRx.c0.mmioRdValid && !cp2af_sRx.c0.mmioWrValid;
      wr_rsp_in = cp2af_sRx.c1.rspValid;
      rd_rsp_id = cp2af_sRx.c0.hdr.mdata[MDATA_ID_MSB -: ID_W];
      wr_rsp_id = cp2af_sRx.c1.hdr.mdata[MDATA_ID_MSB -: ID_W];
      orphan    = 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         rd_hit[i]   = rd_rsp_in && (rd_rsp_id == ID_W'(i));
         wr_hit[i]   = wr_rsp_in && (wr_rsp_id == ID_W'(i));
         if (rd_hit[i] && rd_cnt_q[i] == '0) orphan = 1'b1;
         if (wr_hit[i] && wr_cnt_q[i] == '0) orphan = 1'b1;
         rd_cnt_d[i] = cnt_next(rd_cnt_q[i], rd_gnt[i], rd_hit[i]);
         wr_cnt_d[i] = cnt_next(wr_cnt_q[i], wr_gnt[i], wr_hit[i]);
      end
      if (rd_rsp_in && !(|rd_hit)) orphan = 1'b1;
      if (wr_rsp_in && !(|wr_hit)) orphan = 1'b1;
   end

   always_ff @(posedge clk or posedge SoftReset) begin
      if (SoftReset) begin
         c0_valid_q     <= 1'b0;
         c1_valid_q     <= 1'b0;
         rd_rsp_valid_q <= '0;
         wr_rsp_valid_q <= '0;
         err_q          <= 1'b0;
         for (int i = 0; i < NUM_CLIENTS; i++) begin
            rd_cnt_q[i] <= '0;
            wr_cnt_q[i] <= '0;
         end
      end else begin
         c0_valid_q     <= rd_acc;
         c1_valid_q     <= wr_acc;
         rd_rsp_valid_q <= rd_hit;
         wr_rsp_valid_q <= wr_hit;
         err_q          <= err_q | orphan;
         for (int i = 0; i < NUM_CLIENTS; i++) begin
            rd_cnt_q[i] <= rd_cnt_d[i];
            wr_cnt_q[i] <= wr_cnt_d[i];
         end
      end
   end

   // Headers and data are only meaningful alongside their valids, so they carry no reset.
   always_ff @(posedge clk) begin
      if (rd_acc) c0_hdr_q <= mk_rd_hdr(rd_addr_sel, {rd_gid, rd_tag_sel});
      if (wr_acc) begin
         c1_hdr_q  <= mk_wr_hdr(wr_addr_sel, {wr_gid, wr_tag_sel});
         c1_data_q <= wr_data_sel;
      end
      if (rd_rsp_in) begin
         rd_rsp_tag_q  <= cp2af_sRx.c0.hdr.mdata[CTAG_W-1:0];
         rd_rsp_data_q <= cp2af_sRx.c0.data;
      end
      if (wr_rsp_in) wr_rsp_tag_q <= cp2af_sRx.c1.hdr.mdata[CTAG_W-1:0];
   end

   always_comb begin
      af2cp_sTx          = '0;
      af2cp_sTx.c0.hdr   = c0_hdr_q;
      af2cp_sTx.c0.valid = c0_valid_q;
      af2cp_sTx.c1.hdr   = c1_hdr_q;
      af2cp_sTx.c1.data  = c1_data_q;
      af2cp_sTx.c1.valid = c1_valid_q;
      idle = !c0_valid_q && !c1_valid_q;
      for (int i = 0; i < NUM_CLIENTS; i++)
         if (rd_cnt_q[i] != '0 || wr_cnt_q[i] != '0) idle = 1'b0;
   end

   assign rd_rsp_valid = rd_rsp_valid_q;
   assign rd_rsp_tag   = rd_rsp_tag_q;
   assign rd_rsp_data  = rd_rsp_data_q;
   assign wr_rsp_valid = wr_rsp_valid_q;
   assign wr_rsp_tag   = wr_rsp_tag_q;
   assign err_orphan   = err_q;
   assign unused_rx    = &{1'b0, cp2af_sRx};

endmodule

// File: tb/tb_ccip_mux_bridge.sv
// Directed bench for ccip_mux_bridge: four clients, two outstanding requests per channel.
module tb_ccip_mux_bridge;
   import ccip_if_pkg::*;

   localparam int N    = 4;
   localparam int MAXO = 2;
   localparam int CTW  = 14;

   logic clk = 1'b0;
   logic SoftReset;
   t_if_ccip_Rx rx;
   t_if_ccip_Tx tx;
   logic [N-1:0]          rd_req_valid, rd_req_ready, rd_rsp_valid;
   logic [N-1:0][63:0]    rd_req_addr;
   logic [N-1:0][CTW-1:0] rd_req_tag;
   logic [CTW-1:0]        rd_rsp_tag;
   logic [511:0]          rd_rsp_data;
   logic [N-1:0]          wr_req_valid, wr_req_ready, wr_rsp_valid;
   logic [N-1:0][63:0]    wr_req_addr;
   logic [N-1:0][CTW-1:0] wr_req_tag;
   logic [N-1:0][511:0]   wr_req_data;
   logic [CTW-1:0]        wr_rsp_tag;
   logic                  idle, err_orphan;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ccip_mux_bridge #(.NUM_CLIENTS(N), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .SoftReset(SoftReset), .cp2af_sRx(rx), .af2cp_sTx(tx),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
      .rd_req_tag(rd_req_tag), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_tag(rd_rsp_tag),
      .rd_rsp_data(rd_rsp_data), .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
      .wr_req_addr(wr_req_addr), .wr_req_tag(wr_req_tag), .wr_req_data(wr_req_data),
      .wr_rsp_valid(wr_rsp_valid), .wr_rsp_tag(wr_rsp_tag), .idle(idle), .err_orphan(err_orphan)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      rx = '0;
      rd_req_valid = '0; rd_req_addr = '0; rd_req_tag = '0;
      wr_req_valid = '0; wr_req_addr = '0; wr_req_tag = '0; wr_req_data = '0;
   endtask

   task automatic do_reset();
      SoftReset = 1'b1;
      tick();
      SoftReset = 1'b0;
   endtask

   task automatic test_reset();
      SoftReset = 1'b1;
      rd_req_valid = '1;
      wr_req_valid = '1;
      tick();
      n_cmp++; if (tx.c0.valid !== 1'b0) begin n_bad++; $display("FAIL rst_c0_valid: got %b want 0", tx.c0.valid); end
      n_cmp++; if (tx.c1.valid !== 1'b0) begin n_bad++; $display("FAIL rst_c1_valid: got %b want 0", tx.c1.valid); end
      n_cmp++; if (tx.c2.mmioRdValid !== 1'b0) begin n_bad++; $display("FAIL rst_mmio: got %b want 0", tx.c2.mmioRdValid); end
      n_cmp++; if (rd_req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_rd_ready: got %b want 0000", rd_req_ready); end
      n_cmp++; if (wr_req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_wr_ready: got %b want 0000", wr_req_ready); end
      n_cmp++; if (rd_rsp_valid !== 4'b0000 || wr_rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL rst_rsp_valid: got %b/%b want 0000/0000", rd_rsp_valid, wr_rsp_valid); end
      n_cmp++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_orphan); end
      clear_in();
      SoftReset = 1'b0;
      tick();
      n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL rst_idle: got %b want 1", idle); end
   endtask

   task automatic test_single_read();
      rd_req_addr[0] = 64'h1000;
      rd_req_tag[0]  = 14'h5;
      rd_req_valid   = 4'b0001;
      #1;
      n_cmp++; if (rd_req_ready !== 4'b0001) begin n_bad++; $display("FAIL rd1_ready: got %b want 0001", rd_req_ready); end
      tick();
      rd_req_valid = '0;
      n_cmp++; if (tx.c0.valid !== 1'b1) begin n_bad++; $display("FAIL rd1_c0_valid: got %b want 1", tx.c0.valid); end
      n_cmp++; if (tx.c0.hdr.mdata !== 16'h0005) begin n_bad++; $display("FAIL rd1_mdata: got %h want 0005", tx.c0.hdr.mdata); end
      n_cmp++; if (tx.c0.hdr.address !== 64'h1000) begin n_bad++; $display("FAIL rd1_addr: got %h want 1000", tx.c0.hdr.address); end
      n_cmp++; if (tx.c0.hdr.req_type !== eREQ_RDLINE_I || tx.c0.hdr.vc_sel !== eVC_VA || tx.c0.hdr.cl_len !== eCL_LEN_1)
         begin n_bad++; $display("FAIL rd1_hdr: got type %h vc %h len %h want 0/0/0", tx.c0.hdr.req_type, tx.c0.hdr.vc_sel, tx.c0.hdr.cl_len); end
      tick();
      n_cmp++; if (tx.c0.valid !== 1'b0) begin n_bad++; $display("FAIL rd1_c0_hold: got %b want 0", tx.c0.valid); end
      n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL rd1_busy: got %b want 0", idle); end
      repeat (8) tick();
      rx.c0.rspValid  = 1'b1;
      rx.c0.hdr.mdata = 16'h0005;
      rx.c0.data      = {16{32'hA5A5_0001}};
      tick();
      rx.c0.rspValid = 1'b0;
      n_cmp++; if (rd_rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL rd1_rsp_valid: got %b want 0001", rd_rsp_valid); end
      n_cmp++; if (rd_rsp_tag !== 14'h5) begin n_bad++; $display("FAIL rd1_rsp_tag: got %h want 5", rd_rsp_tag); end
      n_cmp++; if (rd_rsp_data !== {16{32'hA5A5_0001}}) begin n_bad++; $display("FAIL rd1_rsp_data: got %h want a5a50001 x16", rd_rsp_data[63:0]); end
      tick();
      n_cmp++; if (rd_rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL rd1_rsp_pulse: got %b want 0000", rd_rsp_valid); end
      n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL rd1_idle: got %b want 1", idle); end
      // An MMIO write on c0 must not be treated as a memory response.
      rx.c0.rspValid    = 1'b1;
      rx.c0.mmioWrValid = 1'b1;
      rx.c0.hdr.mdata   = 16'h0000;
      tick();
      rx = '0;
      n_cmp++; if (rd_rsp_valid !== 4'b0000 || err_orphan !== 1'b0) begin n_bad++; $display("FAIL rd1_mmio_ignored: got rsp %b err %b want 0000/0", rd_rsp_valid, err_orphan); end
   endtask

   task automatic test_round_robin();
      logic [3:0]  exp_rdy;
      logic [15:0] exp_md;
      do_reset();
      for (int i = 0; i < N; i++) begin
         rd_req_addr[i] = 64'(i) << 12;
         rd_req_tag[i]  = 14'(16 + i);
      end
      rd_req_valid = '1;
      for (int k = 0; k < 8; k++) begin
         exp_rdy = 4'(1 << (k % 4));
         exp_md  = {2'(k % 4), 14'(16 + k % 4)};
         #1;
         n_cmp++; if (rd_req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, rd_req_ready, exp_rdy); end
         tick();
         n_cmp++; if (tx.c0.valid !== 1'b1 || tx.c0.hdr.mdata !== exp_md) begin n_bad++; $display("FAIL rr_mdata[%0d]: got v%b %h want v1 %h", k, tx.c0.valid, tx.c0.hdr.mdata, exp_md); end
      end
      #1;
      n_cmp++; if (rd_req_ready !== 4'b0000) begin n_bad++; $display("FAIL rr_all_capped: got %b want 0000", rd_req_ready); end
      clear_in();
      do_reset();
   endtask

   task automatic test_write_client2();
      wr_req_addr[2] = 64'hDEAD_0000;
      wr_req_tag[2]  = 14'h2A;
      wr_req_data[2] = {8{64'h0123_4567_89AB_CDEF}};
      wr_req_valid   = 4'b0100;
      #1;
      n_cmp++; if (wr_req_ready !== 4'b0100 || rd_req_ready !== 4'b0000) begin n_bad++; $display("FAIL wr_ready: got wr %b rd %b want 0100/0000", wr_req_ready, rd_req_ready); end
      tick();
      wr_req_valid = '0;
      n_cmp++; if (tx.c1.valid !== 1'b1 || tx.c1.hdr.sop !== 1'b1) begin n_bad++; $display("FAIL wr_c1_valid_sop: got %b/%b want 1/1", tx.c1.valid, tx.c1.hdr.sop); end
      n_cmp++; if (tx.c1.hdr.mdata !== 16'h802A) begin n_bad++; $display("FAIL wr_mdata: got %h want 802a", tx.c1.hdr.mdata); end
      n_cmp++; if (tx.c1.hdr.address !== 64'hDEAD_0000 || tx.c1.hdr.req_type !== eREQ_WRLINE_I) begin n_bad++; $display("FAIL wr_hdr: got %h type %h want dead0000 type 0", tx.c1.hdr.address, tx.c1.hdr.req_type); end
      n_cmp++; if (tx.c1.data !== {8{64'h0123_4567_89AB_CDEF}}) begin n_bad++; $display("FAIL wr_data: got %h want 0123456789abcdef x8", tx.c1.data[63:0]); end
      rx.c1.rspValid  = 1'b1;
      rx.c1.hdr.mdata = 16'h802A;
      tick();
      rx = '0;
      n_cmp++; if (wr_rsp_valid !== 4'b0100 || wr_rsp_tag !== 14'h2A) begin n_bad++; $display("FAIL wr_rsp: got %b tag %h want 0100 tag 2a", wr_rsp_valid, wr_rsp_tag); end
      tick();
      n_cmp++; if (idle !== 1'b1 || err_orphan !== 1'b0) begin n_bad++; $display("FAIL wr_idle: got idle %b err %b want 1/0", idle, err_orphan); end
   endtask

   task automatic test_almfull();
      do_reset();
      rx.c0TxAlmFull = 1'b1;
      rd_req_valid   = 4'b0011;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_cmp++; if (rd_req_ready !== 4'b0000) begin n_bad++; $display("FAIL af_ready[%0d]: got %b want 0000", k, rd_req_ready); end
         tick();
         n_cmp++; if (tx.c0.valid !== 1'b0) begin n_bad++; $display("FAIL af_c0_valid[%0d]: got %b want 0", k, tx.c0.valid); end
      end
      rx.c0TxAlmFull = 1'b0;
      #1;
      n_cmp++; if (rd_req_ready !== 4'b0001) begin n_bad++; $display("FAIL af_resume_ready: got %b want 0001", rd_req_ready); end
      tick();
      n_cmp++; if (tx.c0.valid !== 1'b1 || tx.c0.hdr.mdata[15:14] !== 2'd0) begin n_bad++; $display("FAIL af_resume_issue: got v%b id %0d want v1 id 0", tx.c0.valid, tx.c0.hdr.mdata[15:14]); end
      clear_in();
      do_reset();
   endtask

   task automatic test_max_outstanding();
      rd_req_tag[1] = 14'h3;
      rd_req_valid  = 4'b0010;
      #1;
      n_cmp++; if (rd_req_ready !== 4'b0010) begin n_bad++; $display("FAIL mo_first: got %b want 0010", rd_req_ready); end
      tick();
      #1;
      n_cmp++; if (rd_req_ready !== 4'b0010) begin n_bad++; $display("FAIL mo_second: got %b want 0010", rd_req_ready); end
      tick();
      #1;
      n_cmp++; if (rd_req_ready !== 4'b0000) begin n_bad++; $display("FAIL mo_capped: got %b want 0000", rd_req_ready); end
      rx.c0.rspValid  = 1'b1;
      rx.c0.hdr.mdata = 16'h4003;
      tick();
      rx.c0.rspValid = 1'b0;
      n_cmp++; if (rd_rsp_valid !== 4'b0010 || rd_rsp_tag !== 14'h3) begin n_bad++; $display("FAIL mo_rsp: got %b tag %h want 0010 tag 3", rd_rsp_valid, rd_rsp_tag); end
      #1;
      n_cmp++; if (rd_req_ready !== 4'b0010) begin n_bad++; $display("FAIL mo_reopen: got %b want 0010", rd_req_ready); end
      rx.c0.rspValid = 1'b1;
      tick();
      rx.c0.rspValid = 1'b0;
      n_cmp++; if (tx.c0.valid !== 1'b1 || rd_rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL mo_simul: got c0 %b rsp %b want 1/0010", tx.c0.valid, rd_rsp_valid); end
      #1;
      n_cmp++; if (rd_req_ready !== 4'b0010) begin n_bad++; $display("FAIL mo_simul_cnt: got %b want 0010", rd_req_ready); end
      tick();
      #1;
      n_cmp++; if (rd_req_ready !== 4'b0000 || err_orphan !== 1'b0) begin n_bad++; $display("FAIL mo_recap: got %b err %b want 0000/0", rd_req_ready, err_orphan); end
      clear_in();
      do_reset();
   endtask

   task automatic test_orphan();
      rx.c1.rspValid  = 1'b1;
      rx.c1.hdr.mdata = 16'hC007;
      tick();
      rx = '0;
      n_cmp++; if (wr_rsp_valid !== 4'b1000 || wr_rsp_tag !== 14'h7) begin n_bad++; $display("FAIL orph_fwd: got %b tag %h want 1000 tag 7", wr_rsp_valid, wr_rsp_tag); end
      n_cmp++; if (err_orphan !== 1'b1) begin n_bad++; $display("FAIL orph_err: got %b want 1", err_orphan); end
      tick();
      tick();
      n_cmp++; if (err_orphan !== 1'b1) begin n_bad++; $display("FAIL orph_sticky: got %b want 1", err_orphan); end
      n_cmp++; if (idle !== 1'b1 || wr_rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL orph_cnt_zero: got idle %b rsp %b want 1/0000", idle, wr_rsp_valid); end
   endtask

   task automatic test_reset_midburst();
      do_reset();
      n_cmp++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL mb_err_clear: got %b want 0", err_orphan); end
      rd_req_valid = 4'b0111;
      repeat (3) tick();
      rd_req_valid = '0;
      n_cmp++; if (tx.c0.valid !== 1'b1 || tx.c0.hdr.mdata[15:14] !== 2'd2 || idle !== 1'b0) begin n_bad++; $display("FAIL mb_burst: got v%b id %0d idle %b want v1 id 2 idle 0", tx.c0.valid, tx.c0.hdr.mdata[15:14], idle); end
      SoftReset = 1'b1;
      #1;
      n_cmp++; if (tx.c0.valid !== 1'b0 || rd_req_ready !== 4'b0000) begin n_bad++; $display("FAIL mb_async: got c0 %b rdy %b want 0/0000", tx.c0.valid, rd_req_ready); end
      tick();
      SoftReset = 1'b0;
      #1;
      n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL mb_idle: got %b want 1", idle); end
      rd_req_valid = '1;
      #1;
      n_cmp++; if (rd_req_ready !== 4'b0001) begin n_bad++; $display("FAIL mb_restart: got %b want 0001", rd_req_ready); end
      rd_req_valid    = '0;
      rx.c0.rspValid  = 1'b1;
      rx.c0.hdr.mdata = 16'h0000;
      tick();
      rx = '0;
      n_cmp++; if (rd_rsp_valid !== 4'b0001 || err_orphan !== 1'b1) begin n_bad++; $display("FAIL mb_late_rsp: got %b err %b want 0001/1", rd_rsp_valid, err_orphan); end
   endtask

   initial begin
      clear_in();
      SoftReset = 1'b1;
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_client2();
      test_almfull();
      test_max_outstanding();
      test_orphan();
      test_reset_midburst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
